head_flit_route_unit: RTL and testbench

- Parametrised successor to the combinational XY head-flit decoder.
- Computes the output-port request for one input port of a router in a rectangular DIM_X x DIM_Y mesh, using XY or YX dimension-order routing.
- Ages the packet TTL by queueing delay plus one hop, and flags packets that expire or carry an unroutable destination.
- Registered single-stage pipeline with valid/ready handshakes, sitting between the input VC buffer and the switch allocator.

---
 rtl/noc_route_pkg.sv | 47 ++++
 rtl/route_compute.sv | 54 +++++
 rtl/head_flit_route_unit.sv | 153 +++++++++++++++
 tb/tb_head_flit_route_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_route_pkg.sv
// Shared types and helpers for mesh head-flit routing: direction codes, routing modes,
// compact port numbering and saturating TTL ageing.
package noc_route_pkg;

    typedef enum logic [2:0] {
        DirLocal = 3'd0,
        DirEast  = 3'd1,
        DirNorth = 3'd2,
        DirWest  = 3'd3,
        DirSouth = 3'd4
    } dir_e;

    typedef enum logic {
        RouteXy = 1'b0,
        RouteYx = 1'b1
    } route_mode_e;

    // Coordinate field width: at least one bit even for a 2-wide dimension.
    function automatic int coord_width(input int unsigned dim);
        return (dim > 2) ? $clog2(dim) : 1;
    endfunction

    // Ports present on this router are numbered 1..k in E, N, W, S order.
    function automatic int compact_port(input dir_e dir, input int x, input int y,
                                        input int dim_x, input int dim_y);
        int has_e;
        int has_n;
        int has_w;
        int code;
        has_e = (x + 1 < dim_x) ? 1 : 0;
        has_n = (y + 1 < dim_y) ? 1 : 0;
        has_w = (x > 0) ? 1 : 0;
        case (dir)
            DirEast:  code = 1;
            DirNorth: code = has_e + 1;
            DirWest:  code = has_e + has_n + 1;
            DirSouth: code = has_e + has_n + has_w + 1;
            default:  code = 0;
        endcase
        return code;
    endfunction

    function automatic logic [31:0] ttl_age(input logic [31:0] ttl, input logic [31:0] elapsed);
        return (ttl > elapsed) ? ttl - elapsed : 32'd0;
    endfunction

endpackage

// File: rtl/route_compute.sv
// Combinational dimension-order route decision: destination coordinates to a direction,
// flagging destinations that lie outside the mesh.
module route_compute
    import noc_route_pkg::*;
#(
    parameter int          DIM_X = 4,
    parameter int          DIM_Y = 4,
    parameter int          X     = 0,
    parameter int          Y     = 0,
    parameter int          XW    = 2,
    parameter int          YW    = 2,
    parameter route_mode_e MODE  = RouteXy
) (
    input  logic [XW-1:0] dst_x,
    input  logic [YW-1:0] dst_y,
    output dir_e          dir,
    output logic          err
);

    int   dx;
    int   dy;
    dir_e dir_x;
    dir_e dir_y;

    always_comb begin
        dx = int'(dst_x);
        dy = int'(dst_y);

        dir_x = DirLocal;
        if (dx > X) begin
            dir_x = DirEast;
        end else if (dx < X) begin
            dir_x = DirWest;
        end

        dir_y = DirLocal;
        if (dy > Y) begin
            dir_y = DirNorth;
        end else if (dy < Y) begin
            dir_y = DirSouth;
        end

        err = (dx >= DIM_X) || (dy >= DIM_Y);
        dir = DirLocal;
        if (!err) begin
            if (MODE == RouteXy) begin
                dir = (dir_x != DirLocal) ? dir_x : dir_y;
            end else begin
                dir = (dir_y != DirLocal) ? dir_y : dir_x;
            end
        end
    end

endmodule

// File: rtl/head_flit_route_unit.sv
// Registered head-flit route unit: decodes the output-port request, ages the TTL by the
// queueing delay plus one hop, and flags expired or unroutable packets.
module head_flit_route_unit
    import noc_route_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned DIM_X         = 4,
    parameter int unsigned DIM_Y         = 4,
    parameter int unsigned INDEX         = 0,
    parameter int unsigned REQUEST_WIDTH = 3,
    parameter int unsigned ROUTING_MODE  = 0,
    parameter int unsigned COMPACT_PORTS = 1,
    parameter int unsigned TTL_ENABLE    = 1,
    parameter int unsigned TTL_LSB       = 8,
    parameter int unsigned TTL_WIDTH     = 12
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_WIDTH-1:0]    in_flit,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [REQUEST_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0]    out_flit,
    output logic                     out_drop,
    output logic                     out_err
);

    localparam int XW     = coord_width(DIM_X);
    localparam int YW     = coord_width(DIM_Y);
    localparam int NODE_X = int'(INDEX % DIM_X);
    localparam int NODE_Y = int'(INDEX / DIM_X);
    localparam logic [TTL_WIDTH-1:0] WaitMax = '1;

    if (INDEX >= DIM_X * DIM_Y) begin : g_bad_index
        $error("head_flit_route_unit: INDEX lies outside the mesh");
    end
    if (REQUEST_WIDTH < 3) begin : g_bad_request_width
        $error("head_flit_route_unit: REQUEST_WIDTH must be at least 3");
    end
    if (TTL_LSB + TTL_WIDTH > DATA_WIDTH || XW + YW > DATA_WIDTH) begin : g_bad_fields
        $error("head_flit_route_unit: flit fields exceed DATA_WIDTH");
    end
    if (TTL_WIDTH < 1 || TTL_WIDTH > 31) begin : g_bad_ttl_width
        $error("head_flit_route_unit: TTL_WIDTH must be 1..31");
    end

    typedef enum logic {StEmpty, StFull} state_e;

    state_e                   state_q, state_d;
    logic [TTL_WIDTH-1:0]     wait_cnt_q, wait_cnt_d;
    logic [REQUEST_WIDTH-1:0] port_q, port_d;
    logic [DATA_WIDTH-1:0]    flit_q, flit_d;
    logic                     drop_q, drop_d;
    logic                     err_q, err_d;

    dir_e                     route_dir;
    logic                     route_err;
    logic                     accept;
    int                       port_code;
    logic [TTL_WIDTH-1:0]     ttl_new;
    logic [DATA_WIDTH-1:0]    flit_new;
    logic                     drop_new;

    route_compute #(
        .DIM_X (int'(DIM_X)),
        .DIM_Y (int'(DIM_Y)),
        .X     (NODE_X),
        .Y     (NODE_Y),
        .XW    (XW),
        .YW    (YW),
        .MODE  ((ROUTING_MODE == 1) ? RouteYx : RouteXy)
    ) u_route (
        .dst_x (in_flit[YW +: XW]),
        .dst_y (in_flit[0 +: YW]),
        .dir   (route_dir),
        .err   (route_err)
    );

    always_comb begin
        in_ready  = (state_q == StEmpty) || out_ready;
        out_valid = (state_q == StFull);
        accept    = in_valid && in_ready;

        state_d = state_q;
        unique case (state_q)
            StEmpty: if (in_valid) state_d = StFull;
            StFull:  if (out_ready && !in_valid) state_d = StEmpty;
            default: state_d = StEmpty;
        endcase

        wait_cnt_d = wait_cnt_q;
        if (accept) begin
            wait_cnt_d = '0;
        end else if (in_valid && wait_cnt_q != WaitMax) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    always_comb begin
        if (COMPACT_PORTS != 0) begin
            port_code = compact_port(route_dir, NODE_X, NODE_Y, int'(DIM_X), int'(DIM_Y));
        end else begin
            port_code = int'(route_dir);
        end

        // Elapsed hops: cycles spent waiting here plus the hop being taken.
        ttl_new  = TTL_WIDTH'(ttl_age(32'(in_flit[TTL_LSB +: TTL_WIDTH]),
                                      32'(wait_cnt_q) + 32'd1));
        flit_new = in_flit;
        drop_new = route_err;
        if (TTL_ENABLE != 0) begin
            flit_new[TTL_LSB +: TTL_WIDTH] = ttl_new;
            drop_new = route_err || (ttl_new == '0);
        end

        port_d = port_q;
        flit_d = flit_q;
        drop_d = drop_q;
        err_d  = err_q;
        if (accept) begin
            port_d = REQUEST_WIDTH'(port_code);
            flit_d = flit_new;
            drop_d = drop_new;
            err_d  = route_err;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StEmpty;
            wait_cnt_q <= '0;
            port_q     <= '0;
            flit_q     <= '0;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            port_q     <= port_d;
            flit_q     <= flit_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
        end
    end

    assign out_port = port_q;
    assign out_flit = flit_q;
    assign out_drop = drop_q;
    assign out_err  = err_q;

endmodule

// File: tb/tb_head_flit_route_unit.sv
// Bench for head_flit_route_unit: five differently configured units share one stimulus
// stream; a queue-based scoreboard checks each against a behavioural model.
module tb_head_flit_route_unit;

    localparam int NC = 5;
    localparam int C_DIMX   [NC] = '{4, 4, 4, 4, 3};
    localparam int C_DIMY   [NC] = '{4, 4, 4, 4, 3};
    localparam int C_IDX    [NC] = '{5, 5, 0, 4, 4};
    localparam int C_MODE   [NC] = '{0, 1, 0, 0, 0};
    localparam int C_COMPACT[NC] = '{1, 1, 1, 1, 0};
    localparam int C_TTLEN  [NC] = '{1, 1, 1, 0, 1};

    typedef struct {
        logic [NC-1:0][2:0]  port;
        logic [NC-1:0][31:0] flit;
        logic [NC-1:0]       drop;
        logic [NC-1:0]       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_flit = '0;
    logic [NC-1:0] in_rdy;
    logic [NC-1:0] o_valid;
    logic [NC-1:0] o_drop;
    logic [NC-1:0] o_err;
    logic [2:0]    o_port [NC];
    logic [31:0]   o_flit [NC];

    exp_t sb_q[$];
    int   wait_m = 0;
    int   n_cmp  = 0;
    int   n_bad  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        head_flit_route_unit #(
            .DATA_WIDTH    (32),
            .DIM_X         (C_DIMX[g]),
            .DIM_Y         (C_DIMY[g]),
            .INDEX         (C_IDX[g]),
            .REQUEST_WIDTH (3),
            .ROUTING_MODE  (C_MODE[g]),
            .COMPACT_PORTS (C_COMPACT[g]),
            .TTL_ENABLE    (C_TTLEN[g]),
            .TTL_LSB       (8),
            .TTL_WIDTH     (12)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_rdy[g]),
            .in_flit   (in_flit),
            .out_valid (o_valid[g]),
            .out_ready (out_ready),
            .out_port  (o_port[g]),
            .out_flit  (o_flit[g]),
            .out_drop  (o_drop[g]),
            .out_err   (o_err[g])
        );
    end

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: got 0x%0h, want 0x%0h at %0t", name, k, act, exp, $time);
        end
    endtask

    // Direction: 0 local, 1 east, 2 north, 3 west, 4 south; compact mode renumbers by
    // position in the list of ports that physically exist.
    function automatic int ref_port(input int k, input int dx, input int dy, output bit err);
        int x;
        int y;
        int dir;
        int avail[$];
        x   = C_IDX[k] % C_DIMX[k];
        y   = C_IDX[k] / C_DIMX[k];
        err = (dx >= C_DIMX[k]) || (dy >= C_DIMY[k]);
        if (err) return 0;
        if (C_MODE[k] == 0) begin
            dir = (dx > x) ? 1 : (dx < x) ? 3 : (dy > y) ? 2 : (dy < y) ? 4 : 0;
        end else begin
            dir = (dy > y) ? 2 : (dy < y) ? 4 : (dx > x) ? 1 : (dx < x) ? 3 : 0;
        end
        if (C_COMPACT[k] == 0 || dir == 0) return dir;
        if (x < C_DIMX[k] - 1) avail.push_back(1);
        if (y < C_DIMY[k] - 1) avail.push_back(2);
        if (x > 0) avail.push_back(3);
        if (y > 0) avail.push_back(4);
        foreach (avail[i]) if (avail[i] == dir) return i + 1;
        return 7;
    endfunction

    task automatic predict(input logic [31:0] f, input int w, output exp_t e);
        int dx;
        int dy;
        int ttl;
        int nt;
        bit er;
        dx  = int'(f[3:2]);
        dy  = int'(f[1:0]);
        ttl = int'(f[19:8]);
        nt  = (ttl > w + 1) ? ttl - w - 1 : 0;
        for (int k = 0; k < NC; k++) begin
            e.port[k] = 3'(ref_port(k, dx, dy, er));
            e.err[k]  = er;
            e.flit[k] = f;
            e.drop[k] = er;
            if (C_TTLEN[k] != 0) begin
                e.flit[k][19:8] = 12'(nt);
                e.drop[k] = er || (nt == 0);
            end
        end
    endtask

    // Scoreboard: inputs only change just after posedge, so negedge values are what the
    // next posedge will see.
    always @(negedge clk) begin
        exp_t head;
        exp_t e;
        bit   exp_rdy;
        if (!rst) begin
            sb_q.delete();
            wait_m = 0;
            for (int k = 0; k < NC; k++) begin
                check("rst_valid", k, 32'(o_valid[k]), 32'd0);
                check("rst_port", k, 32'(o_port[k]), 32'd0);
                check("rst_flit", k, o_flit[k], 32'd0);
                check("rst_drop", k, 32'(o_drop[k]), 32'd0);
                check("rst_err", k, 32'(o_err[k]), 32'd0);
            end
        end else begin
            exp_rdy = (sb_q.size() == 0) || out_ready;
            for (int k = 0; k < NC; k++) begin
                check("in_ready", k, 32'(in_rdy[k]), 32'(exp_rdy));
                check("out_valid", k, 32'(o_valid[k]), 32'(sb_q.size() != 0));
            end
            if (sb_q.size() != 0) begin
                head = sb_q[0];
                for (int k = 0; k < NC; k++) begin
                    check("out_port", k, 32'(o_port[k]), 32'(head.port[k]));
                    check("out_flit", k, o_flit[k], head.flit[k]);
                    check("out_drop", k, 32'(o_drop[k]), 32'(head.drop[k]));
                    check("out_err", k, 32'(o_err[k]), 32'(head.err[k]));
                end
                if (out_ready) void'(sb_q.pop_front());
            end
            if (in_valid && exp_rdy) begin
                predict(in_flit, wait_m, e);
                sb_q.push_back(e);
                wait_m = 0;
            end else if (in_valid && wait_m < 4095) begin
                wait_m++;
            end
        end
    end

    function automatic logic [31:0] make_flit(input int dx, input int dy, input int ttl);
        logic [31:0] f;
        f       = $urandom;
        f[1:0]  = 2'(dy);
        f[3:2]  = 2'(dx);
        f[19:8] = 12'(ttl);
        return f;
    endfunction

    // Presents one flit and returns just after the edge on which it was taken.
    task automatic send(input int dx, input int dy, input int ttl);
        int n;
        bit acc;
        n        = 0;
        in_valid = 1'b1;
        in_flit  = make_flit(dx, dy, ttl);
        do begin
            @(negedge clk);
            acc = in_rdy[0];
            @(posedge clk);
            #1;
            n++;
        end while (!acc && n < 64);
        if (!acc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout dut0: got in_ready=0, want 1 within 64 cycles");
        end
    endtask

    localparam int ND = 10;
    localparam int D_DX [ND] = '{3, 1, 1, 0, 0, 3, 2, 1, 3, 0};
    localparam int D_DY [ND] = '{0, 1, 3, 2, 0, 3, 1, 2, 1, 3};
    localparam int D_TTL[ND] = '{20, 20, 20, 20, 20, 20, 1, 0, 9, 4095};

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;

        for (int i = 0; i < ND; i++) send(D_DX[i], D_DY[i], D_TTL[i]);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Held result under backpressure while a second flit waits five cycles.
        out_ready = 1'b0;
        send(0, 0, 10);
        in_flit = make_flit(2, 2, 10);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) send(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 15);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset while a result is held.
        out_ready = 1'b0;
        send(1, 2, 30);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        for (int k = 0; k < NC; k++) check("async_rst_valid", k, 32'(o_valid[k]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        out_ready = 1'b1;
        send(3, 0, 20);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 400; i++) begin
            #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_flit   = make_flit(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4095))
                                                              : int'($urandom_range(0, 6)));
            @(posedge clk);
        end
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
